// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, default widths and clog2 for the feedback sum combiner
package fb_pkg;

   localparam logic [1:0] FB_MODE_OFF    = 2'd0;
   localparam logic [1:0] FB_MODE_FB     = 2'd1;
   localparam logic [1:0] FB_MODE_CONST  = 2'd2;
   localparam logic [1:0] FB_MODE_OFFSET = 2'd3;

   localparam int FB_N_CH  = 4;
   localparam int FB_W_IN  = 13;
   localparam int FB_W_OUT = 13;
   localparam int FB_W_CNT = 10;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fb_adder_tree.sv
// rtl/fb_adder_tree.sv - pipelined pairwise adder tree, input register plus clog2(N) sum stages
module fb_adder_tree
   import fb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 15
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N*W-1:0]      in_data,
   output logic signed [W-1:0] sum
);

   localparam int L = clog2(N);

   // One spare zero slot per level lets an odd leftover add zero, keeping every path equally deep.
   logic signed [W-1:0] lvl_d [L+1][N+1];
   logic signed [W-1:0] lvl_q [L+1][N+1];

   always_comb begin
      for (int l = 0; l <= L; l++) begin
         for (int i = 0; i <= N; i++) lvl_d[l][i] = '0;
      end
      for (int i = 0; i < N; i++) lvl_d[0][i] = $signed(in_data[i*W +: W]);
      for (int l = 1; l <= L; l++) begin
         for (int i = 0; 2*i < N; i++) begin
            lvl_d[l][i] = lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l <= L; l++) begin
            for (int i = 0; i <= N; i++) lvl_q[l][i] <= '0;
         end
      end else begin
         for (int l = 0; l <= L; l++) begin
            for (int i = 0; i <= N; i++) lvl_q[l][i] <= lvl_d[l][i];
         end
      end
   end

   assign sum = lvl_q[L][0];

endmodule

// File: rtl/fb_sum_combiner.sv
// rtl/fb_sum_combiner.sv - masked channel sum, mode mux, DAC saturation, sticky status and window sample count
module fb_sum_combiner
   import fb_pkg::*;
#(
   parameter int N_CH  = FB_N_CH,
   parameter int W_IN  = FB_W_IN,
   parameter int W_OUT = FB_W_OUT,
   parameter int W_CNT = FB_W_CNT
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH*W_IN-1:0]    pout_in,
   input  logic                    fb_cond,
   input  logic                    store_strb,
   input  logic [N_CH-1:0]         ch_en_b,
   input  logic [1:0]              mode_b,
   input  logic [W_IN-1:0]         const_dac_b,
   output logic signed [W_OUT-1:0] fb_sgnl,
   output logic                    dac_cond,
   output logic                    sat_flag,
   output logic [W_CNT-1:0]        sample_cnt
);

   localparam int L  = clog2(N_CH);
   localparam int WS = W_IN + L;
   localparam logic signed [WS:0] OMAX = (WS+1)'(2**(W_OUT-1) - 1);
   localparam logic signed [WS:0] OMIN = ~OMAX;

   logic [N_CH-1:0]         ch_en_s_q, ch_en_s_d, ch_en_q, ch_en_d;
   logic [1:0]              mode_s_q, mode_s_d, mode_q, mode_d;
   logic [W_IN-1:0]         const_s_q, const_s_d;
   logic signed [W_IN-1:0]  const_q, const_d;
   logic [L:0]              fbc_q, fbc_d;
   logic signed [W_OUT-1:0] fb_sgnl_q, fb_sgnl_d;
   logic                    dac_cond_q, dac_cond_d;
   logic                    sat_flag_q, sat_flag_d;
   logic                    strb_q, strb_d, strb_p_q, strb_p_d;
   logic [W_CNT-1:0]        cnt_q, cnt_d;
   logic [W_CNT-1:0]        sample_cnt_q, sample_cnt_d;

   logic [N_CH*WS-1:0]      st0_data;
   logic signed [WS-1:0]    tree_sum;
   logic signed [WS:0]      sum_x, const_x, pre;
   logic signed [W_OUT-1:0] sat_val;
   logic                    clip, strb_rise, strb_fall;

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         st0_data[k*WS +: WS] = ch_en_q[k] ? WS'($signed(pout_in[k*W_IN +: W_IN])) : '0;
      end
   end

   fb_adder_tree #(.N(N_CH), .W(WS)) u_tree (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_data (st0_data),
      .sum     (tree_sum)
   );

   always_comb begin
      ch_en_s_d = ch_en_b;
      ch_en_d   = ch_en_s_q;
      mode_s_d  = mode_b;
      mode_d    = mode_s_q;
      const_s_d = const_dac_b;
      const_d   = $signed(const_s_q);
      fbc_d     = {fbc_q[L-1:0], fb_cond};

      sum_x   = (WS+1)'(tree_sum);
      const_x = (WS+1)'(const_q);
      case (mode_q)
         FB_MODE_OFF:   pre = '0;
         FB_MODE_FB:    pre = sum_x;
         FB_MODE_CONST: pre = const_x;
         default:       pre = sum_x + const_x;
      endcase

      clip    = 1'b0;
      sat_val = pre[W_OUT-1:0];
      if (pre > OMAX) begin
         clip    = 1'b1;
         sat_val = {1'b0, {(W_OUT-1){1'b1}}};
      end else if (pre < OMIN) begin
         clip    = 1'b1;
         sat_val = {1'b1, {(W_OUT-1){1'b0}}};
      end

      dac_cond_d = fbc_q[L] & (mode_q != FB_MODE_OFF);
      fb_sgnl_d  = fbc_q[L] ? sat_val : '0;

      // Strobe edges are taken from the registered copy, so window timing lags store_strb by one cycle.
      strb_d    = store_strb;
      strb_p_d  = strb_q;
      strb_rise = strb_q & ~strb_p_q;
      strb_fall = ~strb_q & strb_p_q;

      sat_flag_d = strb_rise ? 1'b0 : (sat_flag_q | (dac_cond_d & clip));

      cnt_d = cnt_q;
      if (strb_rise) begin
         cnt_d = W_CNT'(dac_cond_q);
      end else if (strb_q && dac_cond_q && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
      sample_cnt_d = strb_fall ? cnt_q : sample_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_en_s_q    <= '0;
         ch_en_q      <= '0;
         mode_s_q     <= '0;
         mode_q       <= '0;
         const_s_q    <= '0;
         const_q      <= '0;
         fbc_q        <= '0;
         fb_sgnl_q    <= '0;
         dac_cond_q   <= 1'b0;
         sat_flag_q   <= 1'b0;
         strb_q       <= 1'b0;
         strb_p_q     <= 1'b0;
         cnt_q        <= '0;
         sample_cnt_q <= '0;
      end else begin
         ch_en_s_q    <= ch_en_s_d;
         ch_en_q      <= ch_en_d;
         mode_s_q     <= mode_s_d;
         mode_q       <= mode_d;
         const_s_q    <= const_s_d;
         const_q      <= const_d;
         fbc_q        <= fbc_d;
         fb_sgnl_q    <= fb_sgnl_d;
         dac_cond_q   <= dac_cond_d;
         sat_flag_q   <= sat_flag_d;
         strb_q       <= strb_d;
         strb_p_q     <= strb_p_d;
         cnt_q        <= cnt_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign fb_sgnl    = fb_sgnl_q;
   assign dac_cond   = dac_cond_q;
   assign sat_flag   = sat_flag_q;
   assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fb_sum_combiner.sv
// tb/tb_fb_sum_combiner.sv - directed-vector bench for fb_sum_combiner (N_CH=4, W_IN=W_OUT=13)
module tb_fb_sum_combiner;

   logic              clk;
   logic              rst_n;
   logic [51:0]       pout_in;
   logic              fb_cond;
   logic              store_strb;
   logic [3:0]        ch_en_b;
   logic [1:0]        mode_b;
   logic [12:0]       const_dac_b;
   logic signed [12:0] fb_sgnl, fb_sgnl4;
   logic              dac_cond, dac_cond4;
   logic              sat_flag, sat_flag4;
   logic [9:0]        sample_cnt;
   logic [3:0]        sample_cnt4;

   int n_cmp = 0;
   int n_bad = 0;

   fb_sum_combiner u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pout_in     (pout_in),
      .fb_cond     (fb_cond),
      .store_strb  (store_strb),
      .ch_en_b     (ch_en_b),
      .mode_b      (mode_b),
      .const_dac_b (const_dac_b),
      .fb_sgnl     (fb_sgnl),
      .dac_cond    (dac_cond),
      .sat_flag    (sat_flag),
      .sample_cnt  (sample_cnt)
   );

   fb_sum_combiner #(.W_CNT(4)) u_dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .pout_in     (pout_in),
      .fb_cond     (fb_cond),
      .store_strb  (store_strb),
      .ch_en_b     (ch_en_b),
      .mode_b      (mode_b),
      .const_dac_b (const_dac_b),
      .fb_sgnl     (fb_sgnl4),
      .dac_cond    (dac_cond4),
      .sat_flag    (sat_flag4),
      .sample_cnt  (sample_cnt4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int a, input int b, input int c, input int d);
      pout_in[0  +: 13] = a[12:0];
      pout_in[13 +: 13] = b[12:0];
      pout_in[26 +: 13] = c[12:0];
      pout_in[39 +: 13] = d[12:0];
   endtask

   initial begin
      rst_n       = 1'b1;
      pout_in     = '0;
      fb_cond     = 1'b0;
      store_strb  = 1'b0;
      ch_en_b     = 4'b1111;
      mode_b      = 2'd1;
      const_dac_b = '0;
      set_in(100, 200, -50, 25);
      #3 rst_n = 1'b0;
      tick(3);
      chk("rst_fb_sgnl", fb_sgnl, 0);
      chk("rst_dac_cond", dac_cond, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      rst_n = 1'b1;
      tick(8);

      // single-cycle fb_cond: latency is exactly 4
      fb_cond = 1'b1;
      tick(1);
      fb_cond = 1'b0;
      tick(2);
      chk("lat3_dac_cond", dac_cond, 0);
      tick(1);
      chk("lat4_fb_sgnl", fb_sgnl, 275);
      chk("lat4_dac_cond", dac_cond, 1);
      tick(1);
      chk("lat5_fb_sgnl_off", fb_sgnl, 0);
      chk("lat5_dac_cond_off", dac_cond, 0);

      fb_cond = 1'b1;
      ch_en_b = 4'b0101;
      tick(8);
      chk("mask0101_sum", fb_sgnl, 50);
      ch_en_b = 4'b1111;
      tick(5);
      chk("mask_chg_5cyc_old", fb_sgnl, 50);
      tick(1);
      chk("mask_chg_6cyc_new", fb_sgnl, 275);

      set_in(4095, 4095, 4095, 4095);
      tick(6);
      chk("sat_pos_fb_sgnl", fb_sgnl, 4095);
      chk("sat_pos_flag", sat_flag, 1);
      set_in(-4096, -4096, -4096, -4096);
      tick(6);
      chk("sat_neg_fb_sgnl", fb_sgnl, -4096);
      set_in(100, 200, -50, 25);
      tick(6);
      chk("sat_sticky", sat_flag, 1);
      store_strb = 1'b1;
      tick(1);
      chk("sat_before_clear", sat_flag, 1);
      tick(1);
      chk("sat_cleared", sat_flag, 0);
      tick(3);
      store_strb = 1'b0;
      tick(3);

      mode_b = 2'd2;
      const_dac_b = 13'h1B2E;
      tick(6);
      chk("mode2_const", fb_sgnl, -1234);
      mode_b = 2'd3;
      const_dac_b = 13'd1000;
      tick(6);
      chk("mode3_offset", fb_sgnl, 1275);
      chk("mode3_no_sat", sat_flag, 0);
      const_dac_b = 13'd4000;
      tick(6);
      chk("mode3_sat_fb_sgnl", fb_sgnl, 4095);
      chk("mode3_sat_flag", sat_flag, 1);
      mode_b = 2'd0;
      tick(6);
      chk("mode0_fb_sgnl", fb_sgnl, 0);
      chk("mode0_dac_cond", dac_cond, 0);

      // store window of 50 cycles with 20 fb_cond hits
      mode_b = 2'd1;
      const_dac_b = '0;
      fb_cond = 1'b0;
      tick(8);
      store_strb = 1'b1;
      for (int i = 0; i < 50; i++) begin
         fb_cond = (i >= 10 && i < 30);
         tick(1);
      end
      fb_cond = 1'b0;
      store_strb = 1'b0;
      tick(4);
      chk("cnt_20_hits", sample_cnt, 20);
      chk("cnt_w4_saturates", sample_cnt4, 15);
      chk("cnt_dut4_fb_sgnl_idle", fb_sgnl4, 0);

      // reset in the middle of a window with a full pipeline
      fb_cond = 1'b1;
      store_strb = 1'b1;
      tick(6);
      chk("pre_rst_fb_sgnl", fb_sgnl, 275);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_fb_sgnl", fb_sgnl, 0);
      chk("async_rst_dac_cond", dac_cond, 0);
      chk("async_rst_sample_cnt", sample_cnt, 0);
      store_strb = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      chk("post_rst_5cyc", fb_sgnl, 0);
      tick(1);
      chk("post_rst_6cyc", fb_sgnl, 275);
      chk("post_rst_sample_cnt", sample_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fb_sum_combiner.md
Name: fb_sum_combiner

Overview:
- Parametrised next-generation feedback-signal combiner for the FONT feedback path.
- Accepts N_CH signed per-channel DSP products (I/q, Q/q terms from each BPM) and sums the enabled channels in a pipelined adder tree.
- Saturates the sum to the DAC width and selects the output source: off, feedback, constant, or feedback+constant offset.
- Aligns the DAC-enable flag to the data. Reports sticky saturation status and a per-store-window count of driven samples.

Parameters:
- N_CH, 4: number of input channels; any value from 2 to 16.
- W_IN, 13: signed width of each channel input and of const_dac.
- W_OUT, 13: signed width of fb_sgnl; must satisfy W_OUT <= W_IN + clog2(N_CH).
- W_CNT, 10: width of the sample counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pout_in  in  N_CH*W_IN  packed signed channel products; channel k occupies bits [k*W_IN +: W_IN].
- fb_cond  in  1  feedback-valid flag, aligned with pout_in.
- store_strb  in  1  store window strobe.
- ch_en_b  in  N_CH  channel enable mask; quasi-static; from the slow domain.
- mode_b  in  2  output mode; quasi-static; from the slow domain.
- const_dac_b  in  W_IN  constant/offset value; quasi-static; from the slow domain.
- fb_sgnl  out  W_OUT  signed DAC word.
- dac_cond  out  1  DAC-drive flag, aligned with fb_sgnl.
- sat_flag  out  1  sticky: saturation occurred in the current window.
- sample_cnt  out  W_CNT  number of dac_cond cycles in the last completed store window.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers, fb_sgnl, dac_cond, sat_flag, sample_cnt and the internal counter go to 0. Synchronised config goes to mask=0, mode=0, const=0.
- Config sync: ch_en_b, mode_b and const_dac_b each pass through a 2-FF register chain. New values take effect 2 cycles after they change. No handshake is used; software changes config only outside store windows.
- Stage 0: register each channel as pout_in[k] if ch_en[k] is set, else 0. Sign-extend to WS = W_IN + clog2(N_CH).
- Adder tree: clog2(N_CH) registered stages of pairwise sums. Odd leftovers pass through one register so every path has equal depth. There is no intermediate overflow, given width WS.
- Final stage (registered):
  - mode 0: out = 0.
  - mode 1: out = sum.
  - mode 2: out = const.
  - mode 3: out = sum + sign-extended const, computed at WS+1 bits.
  - The result then saturates to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - fb_sgnl = saturated out when the delayed fb_cond is 1, else 0.
- Latency: LAT = clog2(N_CH) + 2. Inputs and fb_cond at cycle t appear on fb_sgnl and dac_cond at t+LAT; for N_CH=4, LAT=4.
- dac_cond: fb_cond delayed by LAT, ANDed with (mode != 0).
- Saturation: sat_flag sets on any cycle where dac_cond=1 and clamping changed the value. It clears on the rising edge of store_strb; if set and clear occur in the same cycle, the clear wins and the new event sets the flag on the next occurrence.
- Sample counter:
  - Clears on the store_strb rising edge.
  - Increments while store_strb=1 and dac_cond=1; it saturates at all-ones and does not wrap.
  - On the store_strb falling edge, the count is copied to sample_cnt. sample_cnt holds until the next falling edge.
  - A store window shorter than 1 cycle is impossible: store_strb is registered internally for edge detection, adding 1 cycle to edge timing.
- Reset mid-window: pipeline contents are discarded and fb_sgnl drops to 0 immediately. No partial count is latched.

Decomposition:
- Shared package (fb_pkg): the clog2 function, FB_MODE_OFF/FB/CONST/OFFSET mode constants, and the default widths.
- One sub-module: fb_adder_tree (parametrised N, W; pipelined, registered, with equal-depth pass-through). The saturator and mode mux stay inline.

Test Plan:
- N_CH=4, mode=1, mask=1111, inputs 100/200/-50/25, fb_cond=1 -> fb_sgnl=275 and dac_cond=1 exactly 4 cycles later; with fb_cond=0, fb_sgnl=0.
- mask=0101, same inputs -> fb_sgnl=50; change mask to 1111 -> the new sum appears 2 cycles (sync) + 4 (LAT) after the change.
- mode=1, all inputs 4095 -> fb_sgnl=4095 and sat_flag=1. All inputs -4096 -> fb_sgnl=-4096. Next store_strb rising edge -> sat_flag=0.
- mode=2, const=-1234, fb_cond=1 -> fb_sgnl=-1234. mode=3, const=1000, sum=275 -> 1275. mode=3, const=4000, sum=275 -> 4095 with sat_flag set.
- store_strb high 50 cycles with fb_cond high on 20 of them (mode=1) -> sample_cnt=20 after the falling edge. With W_CNT=4 and 20 hits -> sample_cnt=15.
- Assert rst_n low mid-window with a nonzero pipeline -> all outputs 0 asynchronously. After release, first valid output at LAT+2 cycles (config resync).
